fifo_write_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port (shift_in/wdata/full) of the RAM-based FIFO between NUM_REQ producers.
- Each producer uses a valid/ready handshake; the granted producer keeps the port for a burst of up to MAX_BURST words, then the grant rotates.
- Sits directly in front of the FIFO write side; the FIFO read side is untouched.

---
 rtl/fifo_write_arbiter.sv | 145 ++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port (shift_in/wdata/full) between
// NUM_REQ valid/ready producers; each grant lasts up to MAX_BURST words.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_shift_in,
  output logic [WIDTH-1:0]           fifo_wdata,
  output logic                       grant_valid,
  output logic [ID_W-1:0]            grant_id
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic             grant_valid_q, grant_valid_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;

  logic             pick_found_s;
  logic [ID_W-1:0]  pick_id_s;
  logic             g_valid_s;
  logic             xfer_s;
  logic             release_s;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int idx;
    idx          = 0;
    pick_found_s = 1'b0;
    pick_id_s    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (!pick_found_s && req_valid[ID_W'(idx)]) begin
        pick_found_s = 1'b1;
        pick_id_s    = ID_W'(idx);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Write data always follows the granted slice, independent of the strobe.
  always_comb begin
    fifo_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        fifo_wdata = req_data[i*WIDTH +: WIDTH];
      end else begin
        fifo_wdata = fifo_wdata;
      end
    end
  end

  assign g_valid_s = req_valid[grant_id_q];

  // Next-state and handshake outputs; reset masks every transfer strobe.
  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    burst_cnt_d   = burst_cnt_q;
    last_grant_d  = last_grant_q;
    req_ready     = '0;
    fifo_shift_in = 1'b0;
    xfer_s        = 1'b0;
    release_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d       = ST_BURST;
          grant_id_d    = pick_id_s;
          grant_valid_d = 1'b1;
          burst_cnt_d   = '0;
        end else begin
          grant_valid_d = 1'b0;
        end
      end
      ST_BURST: begin
        req_ready[grant_id_q] = !fifo_full;
        xfer_s                = g_valid_s && !fifo_full;
        fifo_shift_in         = xfer_s;
        if (xfer_s) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
        // A full FIFO alone never ends the burst: only the last word or a dropped valid.
        release_s = (xfer_s && (burst_cnt_q == CNT_W'(MAX_BURST - 1))) || !g_valid_s;
        if (release_s) begin
          state_d       = ST_IDLE;
          grant_valid_d = 1'b0;
          last_grant_d  = grant_id_q;
        end else begin
          state_d = ST_BURST;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        grant_valid_d = 1'b0;
      end
    endcase
    if (res) begin
      req_ready     = '0;
      fifo_shift_in = 1'b0;
    end else begin
      fifo_shift_in = fifo_shift_in;
    end
  end

  // State registers; priority restarts at requester 0 after reset.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q       <= ST_IDLE;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      burst_cnt_q   <= '0;
      last_grant_q  <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      burst_cnt_q   <= burst_cnt_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: directed producer tables feed an
// expected-word queue that a negedge monitor checks on every FIFO write strobe.
module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        res;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_shift_in;
  logic [7:0]  fifo_wdata;
  logic        grant_valid;
  logic [1:0]  grant_id;

  logic [1:0]  req_valid1;
  logic [15:0] req_data1;
  logic [1:0]  req_ready1;
  logic        fifo_shift_in1;
  logic [7:0]  fifo_wdata1;
  logic        grant_valid1;
  logic [0:0]  grant_id1;

  fifo_write_arbiter #(.NUM_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .res(res), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_shift_in(fifo_shift_in),
    .fifo_wdata(fifo_wdata), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  fifo_write_arbiter #(.NUM_REQ(2), .WIDTH(8), .MAX_BURST(1)) dut1 (
    .clk(clk), .res(res), .req_valid(req_valid1), .req_data(req_data1),
    .req_ready(req_ready1), .fifo_full(1'b0), .fifo_shift_in(fifo_shift_in1),
    .fifo_wdata(fifo_wdata1), .grant_valid(grant_valid1), .grant_id(grant_id1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   shift_cnt = 0;

  logic [7:0] src_mem [4][16];
  int         src_len [4];
  int         src_pos [4];
  logic       res_drv  = 1'b1;
  logic       full_drv = 1'b0;
  logic [1:0] valid1_drv = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.d  = d;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of producer inputs, then record handshakes at the negedge.
  task automatic cycle();
    @(posedge clk);
    #1;
    res       = res_drv;
    fifo_full = full_drv;
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (src_pos[i] < src_len[i]);
      req_data[i*8 +: 8] = (src_pos[i] < 16) ? src_mem[i][src_pos[i]] : 8'h00;
    end
    req_valid1 = valid1_drv;
    req_data1  = {8'hA5, 8'h5A};
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) src_pos[i]++;
    end
  endtask

  function automatic bit all_done();
    bit d;
    d = 1'b1;
    for (int i = 0; i < 4; i++) if (src_pos[i] < src_len[i]) d = 1'b0;
    return d;
  endfunction

  task automatic run_until_done(input string name, input int budget, output int n);
    n = 0;
    while (!all_done() && n < budget) begin
      cycle();
      n++;
    end
    if (!all_done()) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout after %0d cycles", name, n);
    end
  endtask

  // Scoreboard monitor: every FIFO write must match the next expected word.
  always @(negedge clk) begin
    if (fifo_shift_in === 1'b1) begin
      exp_t e;
      shift_cnt++;
      checks++;
      if (fifo_full) begin
        failures++;
        $display("FAIL shift_while_full: shift_in=1 with fifo_full=1");
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: id=%0d data=%0h, expected none", grant_id, fifo_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({grant_id, fifo_wdata} !== {e.id, e.d}) begin
          failures++;
          $display("FAIL fifo_write: got id=%0d data=%0h expected id=%0d data=%0h",
                   grant_id, fifo_wdata, e.id, e.d);
        end
      end
    end
  end

  initial begin
    int n;
    int s0;
    res = 1'b1; fifo_full = 1'b0; req_valid = '0; req_data = '0;
    req_valid1 = '0; req_data1 = '0;
    for (int i = 0; i < 4; i++) begin src_len[i] = 0; src_pos[i] = 0; end

    // Reset and quiet idle.
    cycle();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_shift", 32'(fifo_shift_in), 32'h0);
    cycle();
    res_drv = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("idle_gv", 32'(grant_valid), 32'h0);
      chk("idle_shift", 32'(fifo_shift_in), 32'h0);
      chk("idle_ready", 32'(req_ready), 32'h0);
    end

    // All four requesters continuously valid, 8 words each.
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 8; src_pos[i] = 0;
      for (int k = 0; k < 8; k++) src_mem[i][k] = 8'(16 * i + k);
    end
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++)
        for (int k = 0; k < 4; k++) push(2'(i), 8'(16 * i + 4 * r + k));
    s0 = shift_cnt;
    run_until_done("rr_all", 200, n);
    chk("rr_cycles", 32'(n), 32'd40);
    cycle();
    chk("rr_release_gv", 32'(grant_valid), 32'h0);
    chk("rr_shifts", 32'(shift_cnt - s0), 32'd32);

    // Only requester 2, two words, then valid drops.
    src_len[2] = 2; src_pos[2] = 0; src_mem[2][0] = 8'hA0; src_mem[2][1] = 8'hA1;
    push(2'd2, 8'hA0); push(2'd2, 8'hA1);
    cycle();
    chk("r2_idle_gv", 32'(grant_valid), 32'h0);
    cycle();
    chk("r2_grant", 32'({grant_valid, grant_id}), 32'h6);
    cycle();
    cycle();
    chk("r2_drop_shift", 32'(fifo_shift_in), 32'h0);
    chk("r2_drop_gv", 32'(grant_valid), 32'h1);
    cycle();
    chk("r2_after_gv", 32'(grant_valid), 32'h0);

    // Requester 1 stalled by fifo_full for 3 cycles after its 2nd word.
    src_len[1] = 5; src_pos[1] = 0;
    for (int k = 0; k < 5; k++) begin
      src_mem[1][k] = 8'(8'hB0 + k);
      push(2'd1, 8'(8'hB0 + k));
    end
    cycle(); cycle(); cycle();
    full_drv = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("full_ready", 32'(req_ready), 32'h0);
      chk("full_shift", 32'(fifo_shift_in), 32'h0);
      chk("full_gv", 32'({grant_valid, grant_id}), 32'h5);
    end
    full_drv = 1'b0;
    cycle();
    chk("full_resume", 32'(fifo_shift_in), 32'h1);
    cycle();
    chk("full_last", 32'(fifo_shift_in), 32'h1);
    cycle();
    chk("full_burst_end", 32'({grant_valid, fifo_shift_in}), 32'h0);
    run_until_done("full_tail", 20, n);
    cycle(); cycle();

    // Reset one cycle after requester 3's first word; priority restarts at 0.
    src_len[3] = 4; src_pos[3] = 0;
    for (int k = 0; k < 4; k++) src_mem[3][k] = 8'(8'hC0 + k);
    push(2'd3, 8'hC0);
    cycle(); cycle();
    res_drv = 1'b1;
    cycle();
    chk("mid_rst_shift", 32'(fifo_shift_in), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    res_drv = 1'b0;
    src_len[3] = 2;
    src_len[1] = 1; src_pos[1] = 0; src_mem[1][0] = 8'hD0;
    push(2'd1, 8'hD0); push(2'd3, 8'hC1);
    cycle();
    cycle();
    chk("post_rst_grant", 32'({grant_valid, grant_id}), 32'h5);
    run_until_done("post_rst", 20, n);
    cycle(); cycle();

    // MAX_BURST=1 instance, two requesters always valid: strict alternation.
    valid1_drv = 2'b11;
    for (int c = 0; c < 8; c++) begin
      cycle();
      chk("mb1_shift", 32'(fifo_shift_in1), 32'(c % 2));
      if (c % 2 == 1) begin
        chk("mb1_id", 32'(grant_id1), 32'(((c - 1) / 2) % 2));
        chk("mb1_data", 32'(fifo_wdata1), (((c - 1) / 2) % 2 == 0) ? 32'h5A : 32'hA5);
      end
    end
    valid1_drv = 2'b00;
    cycle(); cycle();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
